// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - vga_state_t : run/stop state machine encoding
//   - DEF_*       : default 800x600@72 timing constants
//   - axis_total  : derives the total count (active + porches + sync) of one axis
package vga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } vga_state_t;

   localparam int unsigned DEF_H_ACT  = 32'd800;
   localparam int unsigned DEF_H_FP   = 32'd56;
   localparam int unsigned DEF_H_SYNC = 32'd120;
   localparam int unsigned DEF_H_BP   = 32'd64;
   localparam int unsigned DEF_V_ACT  = 32'd600;
   localparam int unsigned DEF_V_FP   = 32'd37;
   localparam int unsigned DEF_V_SYNC = 32'd6;
   localparam int unsigned DEF_V_BP   = 32'd23;

   function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- a wrap counter plus sync-window decode.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ce          pixel clock enable; the counter and sync flop update only when high
//   inc         advance the count (wraps from TOT-1 to 0)
//   clear       force the count to 0 (overrides inc)
//   run         the raster is live after this edge; gates the sync decode
//   cnt         current count (registered)
//   wrap        inc is high and the count sits at TOT-1 (independent of clear)
//   act_nxt     the count about to be loaded lies inside the active area
//   sync_out    registered sync, polarity POL, aligned with cnt
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACT  = DEF_H_ACT,
   parameter int unsigned FP   = DEF_H_FP,
   parameter int unsigned SYNC = DEF_H_SYNC,
   parameter int unsigned BP   = DEF_H_BP,
   parameter int unsigned W    = 32'd11,
   parameter bit          POL  = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         inc,
   input  logic         clear,
   input  logic         run,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         act_nxt,
   output logic         sync_out
);

   localparam int unsigned TOT = axis_total(ACT, FP, SYNC, BP);
   // One extra bit so window bounds equal to 2**W still compare correctly.
   localparam logic [W:0] LAST_L    = (W+1)'(TOT - 32'd1);
   localparam logic [W:0] ACT_L     = (W+1)'(ACT);
   localparam logic [W:0] SYNC_LO_L = (W+1)'(ACT + FP);
   localparam logic [W:0] SYNC_HI_L = (W+1)'(ACT + FP + SYNC);

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_nxt_s;
   logic [W:0]   cnt_ext_s;
   logic         at_last_s;
   logic         in_sync_s;

   assign at_last_s = ({1'b0, cnt_r} == LAST_L);
   // Kept apart from clear so the top can derive clear from wrap without a loop.
   assign wrap      = inc && at_last_s;

   // Next count: clear beats inc; inc wraps at TOT-1.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clear) begin
         cnt_nxt_s = {W{1'b0}};
      end else if (inc) begin
         if (at_last_s) begin
            cnt_nxt_s = {W{1'b0}};
         end else begin
            cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Decode the value being loaded so the registered outputs line up with cnt.
   assign cnt_ext_s = {1'b0, cnt_nxt_s};
   assign act_nxt   = (cnt_ext_s < ACT_L);
   assign in_sync_s = (cnt_ext_s >= SYNC_LO_L) && (cnt_ext_s < SYNC_HI_L);

   // Count and sync registers, advanced on pixel-enable edges only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {W{1'b0}};
         sync_out <= ~POL;
      end else if (ce) begin
         cnt_r    <= cnt_nxt_s;
         sync_out <= (run && in_sync_s) ? POL : ~POL;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with a run/stop
// state machine that only stops on a frame boundary.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds 16-bit frame_cnt_out).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pix_ce            pixel clock enable; raster advances only when high
//   en                run request
//   hsync_out         horizontal sync, polarity H_POL
//   vsync_out         vertical sync, polarity V_POL
//   color_en_out      high inside the active area
//   x_out, y_out      horizontal / vertical counts
//   line_start_out    one-clk pulse when x becomes 0
//   frame_start_out   one-clk pulse when x and y become 0
//   frame_cnt_out     frame_start pulse count (only with VGA_TIMING_FRAME_CNT_EN)
//   busy_out          state machine is not idle
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT  = DEF_H_ACT,
   parameter int unsigned H_FP   = DEF_H_FP,
   parameter int unsigned H_SYNC = DEF_H_SYNC,
   parameter int unsigned H_BP   = DEF_H_BP,
   parameter int unsigned V_ACT  = DEF_V_ACT,
   parameter int unsigned V_FP   = DEF_V_FP,
   parameter int unsigned V_SYNC = DEF_V_SYNC,
   parameter int unsigned V_BP   = DEF_V_BP,
   parameter bit          H_POL  = 1'b1,
   parameter bit          V_POL  = 1'b1,
   parameter int unsigned H_W    = 32'd11,
   parameter int unsigned V_W    = 32'd10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pix_ce,
   input  logic           en,
   output logic           hsync_out,
   output logic           vsync_out,
   output logic           color_en_out,
   output logic [H_W-1:0] x_out,
   output logic [V_W-1:0] y_out,
   output logic           line_start_out,
   output logic           frame_start_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic [15:0]    frame_cnt_out,
`endif
   output logic           busy_out
);

   vga_state_t state_r;
   vga_state_t state_nxt_s;
   logic       running_s;
   logic       run_nxt_s;
   logic       clear_s;
   logic       h_wrap_s;
   logic       v_wrap_s;
   logic       h_act_nxt_s;
   logic       v_act_nxt_s;
   logic       line_nxt_s;
   logic       frame_nxt_s;

   assign running_s = (state_r != ST_IDLE);

   // Next state from the pre-edge state only; v_wrap_s marks the last pixel of a frame.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en) state_nxt_s = ST_RUN;
            else    state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (en) state_nxt_s = ST_RUN;
            else    state_nxt_s = ST_STOP;
         end
         ST_STOP: begin
            if (en)            state_nxt_s = ST_RUN;
            else if (v_wrap_s) state_nxt_s = ST_IDLE;
            else               state_nxt_s = ST_STOP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   assign run_nxt_s   = (state_nxt_s != ST_IDLE);
   assign clear_s     = !run_nxt_s;
   // Leaving IDLE presents x=0,y=0, which counts as both a line and a frame start.
   assign line_nxt_s  = run_nxt_s && (!running_s || h_wrap_s);
   assign frame_nxt_s = run_nxt_s && (!running_s || v_wrap_s);

   vga_axis_counter #(
      .ACT (H_ACT), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (H_W), .POL (H_POL)
   ) u_h_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (pix_ce),
      .inc      (running_s),
      .clear    (clear_s),
      .run      (run_nxt_s),
      .cnt      (x_out),
      .wrap     (h_wrap_s),
      .act_nxt  (h_act_nxt_s),
      .sync_out (hsync_out)
   );

   vga_axis_counter #(
      .ACT (V_ACT), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (V_W), .POL (V_POL)
   ) u_v_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (pix_ce),
      .inc      (h_wrap_s),
      .clear    (clear_s),
      .run      (run_nxt_s),
      .cnt      (y_out),
      .wrap     (v_wrap_s),
      .act_nxt  (v_act_nxt_s),
      .sync_out (vsync_out)
   );

   // State and registered decode; strobes fall back to 0 on any clk without pix_ce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         color_en_out    <= 1'b0;
         line_start_out  <= 1'b0;
         frame_start_out <= 1'b0;
         busy_out        <= 1'b0;
      end else if (pix_ce) begin
         state_r         <= state_nxt_s;
         color_en_out    <= run_nxt_s && h_act_nxt_s && v_act_nxt_s;
         line_start_out  <= line_nxt_s;
         frame_start_out <= frame_nxt_s;
         busy_out        <= run_nxt_s;
      end else begin
         line_start_out  <= 1'b0;
         frame_start_out <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   // Frame counter: steps with each frame_start pulse, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_out <= 16'd0;
      end else if (pix_ce && frame_nxt_s) begin
         frame_cnt_out <= frame_cnt_out + 16'd1;
      end
   end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 800x600 sync block.
- Generates hsync/vsync/colour-enable, pixel coordinates, and line/frame strobes for the pixel-source logic of the display path.
- Generalised in resolution, porches, sync polarity, and pixel-clock-enable rate.
- Adds a run/stop state machine that stops only on a frame boundary.

Parameters:
- H_ACT, 800, active pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACT, 600, active lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- H_W, 11, horizontal counter width; must hold H_TOT-1
- V_W, 10, vertical counter width; must hold V_TOT-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable; the raster advances only on cycles with pix_ce=1
- en  in  1  run request
- hsync_out  out  1  horizontal sync, polarity H_POL
- vsync_out  out  1  vertical sync, polarity V_POL
- color_en_out  out  1  high inside the active area
- x_out  out  H_W  horizontal count
- y_out  out  V_W  vertical count
- line_start_out  out  1  one-clk pulse when x becomes 0
- frame_start_out  out  1  one-clk pulse when x=0 and y becomes 0
- busy_out  out  1  state != IDLE

Behaviour:
- Derived constants: H_TOT = H_ACT+H_FP+H_SYNC+H_BP (default 1040); V_TOT likewise (default 666).
- Reset: asynchronous on rst_n low, released synchronously to clk.
  - state=IDLE, x=0, y=0
  - hsync_out=!H_POL, vsync_out=!V_POL
  - color_en_out=0, strobes=0, busy_out=0
- Output timing: all outputs are registered. Decode is aligned with the x/y values presented in the same cycle, so no combinational path runs from counters to pins.
- State and counter updates happen only on clk edges with pix_ce=1. With pix_ce=0, everything holds, and the strobes drop to 0 after one clk.
- Counting:
  - x wraps from H_TOT-1 to 0.
  - y increments only when x wraps, and wraps from V_TOT-1 to 0.
- Decode while RUN/STOP:
  - hsync active for x in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC)
  - vsync active for y in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC) over entire lines
  - color_en_out = (x<H_ACT) && (y<V_ACT)
- Strobes:
  - line_start_out: 1 for exactly one clk on the pix_ce edge that loads x=0 in RUN/STOP.
  - frame_start_out: same, and only when y is also 0.
- FSM states: IDLE, RUN, STOP.
  - IDLE: counters held at 0, syncs inactive, color_en 0. On pix_ce with en=1, go to RUN; x=0, y=0 are presented with line_start and frame_start pulsed.
  - RUN: counts. On pix_ce with en=0, go to STOP.
  - STOP: keeps counting. On pix_ce with en=1, return to RUN with no raster disturbance. On the pix_ce where x=H_TOT-1 and y=V_TOT-1, go to IDLE; counters become 0, outputs go inactive, no strobe.
- Simultaneous events: if en drops on the last pixel of a frame while in RUN, go to STOP (not IDLE); the next full frame is then emitted. Rationale: decisions use the pre-edge state only.
- Mid-frame stop request: never truncates a frame. Only rst_n truncates.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Extra port frame_cnt_out, out, 16 bits.
  - Reset value 0.
  - Increments (wrap 0xFFFF to 0) on every frame_start_out pulse, including the first after IDLE.
  - Held while IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package vga_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, STOP=2'd2)
  - default 800x600@72 timing constants
  - a localparam-style H_TOT/V_TOT derivation helper
- One natural sub-module, vga_axis_counter: one wrap counter plus window decode, parametrised by ACT/FP/SYNC/BP/W, with inc and clear inputs and a wrap output.
  - Instantiated twice; the horizontal wrap drives the vertical inc.
- FSM and strobe logic stay in the top.

Test Plan:
Small configuration for all tests: H=8/2/3/2 (H_TOT 15), V=4/1/2/1 (V_TOT 8), pols=1, pix_ce=1.
1. Reset with en=0, then run 100 clks: all outputs stay at reset values, busy_out=0, x=y=0.
2. en=1 from cycle 0:
   - frame_start_out pulses every 120 clks; line_start_out every 15.
   - hsync high for x=10..12.
   - vsync high for y=5..6 (30 clks).
   - color_en high for 32 clks per frame.
3. pix_ce toggling 1-in-3, same config: all periods scale by 3 (frame 360 clks); strobes stay 1 clk wide.
4. en dropped at x=3, y=2:
   - Counting continues to x=14, y=7.
   - Then IDLE, busy_out=0, no further strobes.
   - en re-raised during STOP: no gap, next frame_start lands exactly 120 clks after the previous one.
5. rst_n asserted asynchronously mid-line at x=6: outputs go to reset values immediately without waiting for clk. After release with en=1, x restarts at 0.
6. Build with VGA_TIMING_FRAME_CNT_EN: frame_cnt_out=1 after the first frame_start and 5 after five frames. It holds through STOP→IDLE and resets to 0 on rst_n.
